// File: rtl/loop_decoder.sv
// loop_decoder: fetch/decode sequencer for the SIMD array with registered issue controls
// and a zero-overhead hardware loop stack.
module loop_decoder #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 4,
  parameter int LOOP_DEPTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic                                 stall,
  input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] instruction,
  output logic [INS_ADDR_WIDTH-1:0]            pc,
  output logic                                 issue_valid,
  output logic [1:0]                           pe_op,
  output logic [1:0]                           dot_ctrl,
  output logic                                 r_select,
  output logic                                 write_en,
  output logic [ADDR_WIDTH-1:0]                a_addr,
  output logic [ADDR_WIDTH-1:0]                b_addr,
  output logic [ADDR_WIDTH-1:0]                r_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]      loop_level
);
  localparam int IW = INS_ADDR_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int OW = OPCODE_WIDTH;
  localparam int LW = $clog2(LOOP_DEPTH+1);
  localparam logic [OW-1:0] OP_LOOP = OW'(8);
  localparam logic [OW-1:0] OP_HALT = OW'(9);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [LW-1:0] lvl_q, lvl_d, top;
  logic err_q, err_d;
  logic [IW-1:0] ls_q [2**LW];
  logic [IW-1:0] le_q [2**LW];
  logic [AW-1:0] lr_q [2**LW];
  logic [OW-1:0] op;
  logic [AW-1:0] fa, fb, fr;
  logic [IW-1:0] lend, seq;
  logic go, is_loop, bad_loop, jump, full, pushable, push, at_end, back, pop, iss;
  logic iv_q, rs_q, we_q;
  logic [1:0] pe_q, dot_q;
  logic [AW-1:0] a_q, b_q, r_q;
  assign {fa, fb, fr, op} = instruction;
  assign lend = fr[IW-1:0];
  assign top = lvl_q - 1'b1;
  assign go = state_q == EXEC && !stall;
  assign is_loop = op == OP_LOOP;
  assign bad_loop = is_loop && lend <= pc_q;
  assign jump = is_loop && !bad_loop && fa == '0;
  assign full = lvl_q == LW'(LOOP_DEPTH);
  assign pushable = is_loop && !bad_loop && fa != '0 && !full;
  assign push = go && pushable;
  // Loop-back is skipped when this instruction itself redirected pc or opened a new loop.
  assign at_end = lvl_q != '0 && pc_q == le_q[top] && !jump && !pushable && op != OP_HALT;
  assign back = at_end && lr_q[top] > AW'(1);
  assign pop = at_end && lr_q[top] == AW'(1);
  assign seq = jump ? lend : pc_q;
  assign iss = go && op != '0 && op < OP_LOOP;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    lvl_d = lvl_q;
    err_d = err_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = FETCH;
      pc_d = '0;
      lvl_d = '0;
      err_d = 1'b0;
    end else if (state_q == FETCH) begin
      state_d = EXEC;
    end else if (go) begin
      err_d = err_q || op > OP_HALT || bad_loop || (is_loop && !bad_loop && fa != '0 && full);
      lvl_d = push ? lvl_q + 1'b1 : pop ? lvl_q - 1'b1 : lvl_q;
      // Stepping past the last address ends the program instead of wrapping pc.
      if (op == OP_HALT || (!back && &seq)) begin
        state_d = DONE;
      end else begin
        state_d = FETCH;
        pc_d = back ? ls_q[top] : seq + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
      iv_q <= 1'b0;
      pe_q <= 2'b00;
      dot_q <= 2'b00;
      rs_q <= 1'b0;
      we_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
      iv_q <= iss;
      pe_q <= !iss ? 2'b00 : op == OW'(1) ? 2'b01 : op == OW'(2) ? 2'b10 : op == OW'(7) ? 2'b00 : 2'b11;
      dot_q <= !iss ? 2'b00 : op == OW'(4) ? 2'b01 : op == OW'(5) ? 2'b10 : op == OW'(6) ? 2'b11 : 2'b00;
      rs_q <= iss && op >= OW'(4) && op <= OW'(6);
      we_q <= iss;
      a_q <= iss ? fa : '0;
      b_q <= iss ? fb : '0;
      r_q <= iss ? fr : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      ls_q[lvl_q] <= pc_q + 1'b1;
      le_q[lvl_q] <= lend;
      lr_q[lvl_q] <= fa;
    end
    if (rstn && go && back) lr_q[top] <= lr_q[top] - 1'b1;
  end
  assign pc = pc_q;
  assign issue_valid = iv_q;
  assign pe_op = pe_q;
  assign dot_ctrl = dot_q;
  assign r_select = rs_q;
  assign write_en = we_q;
  assign a_addr = a_q;
  assign b_addr = b_q;
  assign r_addr = r_q;
  assign busy = state_q == FETCH || state_q == EXEC;
  assign done = state_q == DONE;
  assign err = err_q;
  assign loop_level = lvl_q;
endmodule

// File: tb/tb_loop_decoder.sv
// tb_loop_decoder: directed and random programs scored against an instruction-level
// reference interpreter of the loop decoder.
module tb_loop_decoder;
  localparam int IW = 10, AW = 10, OW = 4, DEPTH = 2, N = 1 << IW;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stall = 1'b0;
  logic [OW+3*AW-1:0] instruction = '0;
  logic [IW-1:0] pc;
  logic issue_valid, r_select, write_en, busy, done, err;
  logic [1:0] pe_op, dot_ctrl, loop_level;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  loop_decoder #(.INS_ADDR_WIDTH(IW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .LOOP_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall), .instruction(instruction),
    .pc(pc), .issue_valid(issue_valid), .pe_op(pe_op), .dot_ctrl(dot_ctrl),
    .r_select(r_select), .write_en(write_en), .a_addr(a_addr), .b_addr(b_addr),
    .r_addr(r_addr), .busy(busy), .done(done), .err(err), .loop_level(loop_level)
  );
  always #5 clk = ~clk;
  logic [OW+3*AW-1:0] mem [N];
  always @(posedge clk) instruction <= mem[pc];
  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  int cyc = 0;
  bit mon = 0, prev_iv = 0;
  logic [35:0] obs [$];
  int obs_t [$];
  int obs_l [$];
  always @(negedge clk) begin
    cyc++;
    if (mon) begin
      if (issue_valid) begin
        check("gap", prev_iv, 0);
        obs.push_back({pe_op, dot_ctrl, r_select, write_en, a_addr, b_addr, r_addr});
        obs_t.push_back(cyc);
        obs_l.push_back(int'(loop_level));
      end else check("quiet", {write_en, dot_ctrl, r_select}, 0);
    end
    prev_iv = issue_valid;
  end
  function automatic logic [OW+3*AW-1:0] mk(int op, int a, int b, int r);
    return {AW'(a), AW'(b), AW'(r), OW'(op)};
  endfunction
  function automatic logic [35:0] pack(int op, int a, int b, int r);
    logic [1:0] pe, dot;
    logic rs;
    pe = 2'b11; dot = 2'b00; rs = 1'b0;
    case (op)
      1: pe = 2'b01;
      2: pe = 2'b10;
      4: begin dot = 2'b01; rs = 1'b1; end
      5: begin dot = 2'b10; rs = 1'b1; end
      6: begin dot = 2'b11; rs = 1'b1; end
      7: pe = 2'b00;
      default: ;
    endcase
    return {pe, dot, rs, 1'b1, AW'(a), AW'(b), AW'(r)};
  endfunction
  typedef struct {int s; int e; int r;} ent_t;
  logic [35:0] exp_q [$];
  int exp_pc, exp_lvl;
  bit exp_err;
  function automatic bit ref_run();
    ent_t stk [$];
    ent_t t;
    int p, nx, op, a, b, r, steps;
    bit handled;
    p = 0; steps = 0;
    exp_q.delete(); exp_err = 0;
    while (1) begin
      steps++;
      if (steps > 5000) return 0;
      op = int'(mem[p][3:0]); r = int'(mem[p][13:4]); b = int'(mem[p][23:14]); a = int'(mem[p][33:24]);
      if (op == 9) break;
      if (op >= 1 && op <= 7) exp_q.push_back(pack(op, a, b, r));
      if (op >= 10) exp_err = 1;
      nx = p + 1; handled = 0;
      if (op == 8) begin
        if (r % N <= p) exp_err = 1;
        else if (a == 0) begin nx = r % N + 1; handled = 1; end
        else if (stk.size() == DEPTH) exp_err = 1;
        else begin t.s = p + 1; t.e = r % N; t.r = a; stk.push_back(t); handled = 1; end
      end
      if (!handled && stk.size() > 0 && stk[$].e == p) begin
        t = stk.pop_back();
        if (t.r > 1) begin t.r--; stk.push_back(t); nx = t.s; end
      end
      if (nx >= N) break;
      p = nx;
    end
    exp_pc = p; exp_lvl = stk.size();
    return 1;
  endfunction
  task automatic clr();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask
  task automatic run_prog(input string name, input int pct, input int s_from, input int s_len,
                          input int restart, output int ts);
    int n;
    n = 0;
    void'(ref_run());
    obs.delete(); obs_t.delete(); obs_l.delete();
    @(negedge clk); #1;
    ts = cyc; start = 1'b1;
    do begin
      @(negedge clk); #1;
      start = restart != 0 && cyc - ts == restart;
      stall = (cyc - ts >= s_from && cyc - ts < s_from + s_len) || $urandom_range(99) < pct;
      n++;
    end while (!done && n < 20000);
    start = 1'b0; stall = 1'b0;
    check({name, ":done"}, done, 1);
    check({name, ":count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) check({name, ":issue"}, obs[i], exp_q[i]);
    check({name, ":pc"}, pc, exp_pc);
    check({name, ":err"}, err, exp_err);
    check({name, ":lvl"}, loop_level, exp_lvl);
    check({name, ":busy"}, busy, 0);
  endtask
  task automatic gen();
    int L, k, e;
    do begin
      clr();
      L = $urandom_range(4, 24);
      for (int p = 0; p < L - 1; p++) begin
        k = $urandom_range(99);
        if (k < 45) mem[p] = mk($urandom_range(1, 7), $urandom, $urandom, $urandom);
        else if (k < 55) mem[p] = '0;
        else if (k < 62) mem[p] = mk($urandom_range(10, 15), $urandom, $urandom, $urandom);
        else begin
          e = p + $urandom_range(0, 4) - 1;
          if (e < 0) e = 0;
          if (e > L - 2) e = L - 2;
          mem[p] = mk(8, $urandom_range(0, 3), $urandom, e);
        end
      end
      mem[L-1] = mk(9, 0, 0, 0);
    end while (!ref_run());
  endtask
  task automatic load_basic();
    clr();
    mem[0] = mk(1, 1, 2, 3); mem[1] = mk(2, 4, 5, 6); mem[2] = mk(3, 7, 8, 9); mem[3] = mk(9, 0, 0, 0);
  endtask
  initial begin
    int ts;
    clr();
    repeat (2) @(negedge clk);
    check("rst_iv", issue_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_lvl", loop_level, 0);
    rstn = 1'b1;
    mon = 1;
    load_basic();
    run_prog("basic", 0, 0, 0, 0, ts);
    check("basic_t0", obs_t[0] - ts, 3);
    check("basic_t1", obs_t[1] - ts, 5);
    check("basic_t2", obs_t[2] - ts, 7);
    clr();
    mem[0] = mk(8, 3, 0, 2); mem[1] = mk(5, 1, 2, 3); mem[2] = mk(4, 4, 5, 6); mem[3] = mk(9, 0, 0, 0);
    run_prog("loop3", 0, 0, 0, 0, ts);
    check("loop3_lvl_body", obs_l[0], 1);
    clr();
    mem[0] = mk(8, 2, 0, 5); mem[1] = mk(8, 3, 0, 4); mem[4] = mk(1, 1, 1, 1); mem[5] = mk(2, 2, 2, 2);
    mem[6] = mk(9, 0, 0, 0);
    run_prog("nest", 20, 0, 0, 0, ts);
    clr();
    mem[0] = mk(8, 2, 0, 6); mem[1] = mk(8, 2, 0, 5); mem[2] = mk(8, 2, 0, 4); mem[4] = mk(1, 1, 1, 1);
    mem[5] = mk(2, 2, 2, 2); mem[6] = mk(3, 3, 3, 3); mem[7] = mk(9, 0, 0, 0);
    run_prog("full", 0, 0, 0, 0, ts);
    check("full_err", err, 1);
    clr();
    mem[0] = mk(8, 0, 0, 4);
    for (int i = 1; i <= 4; i++) mem[i] = mk(1, i, i, i);
    mem[5] = mk(9, 0, 0, 0);
    run_prog("skip", 0, 0, 0, 0, ts);
    check("skip_pc", pc, 5);
    clr();
    mem[0] = mk(3, 9, 8, 7); mem[1] = mk(9, 0, 0, 0);
    run_prog("stall", 0, 2, 4, 0, ts);
    check("stall_t", obs_t[0] - ts, 7);
    clr();
    mem[0] = mk(12, 0, 0, 0); mem[1] = mk(1, 5, 5, 5); mem[2] = mk(9, 0, 0, 0);
    run_prog("illegal", 0, 0, 0, 0, ts);
    check("illegal_err", err, 1);
    load_basic();
    run_prog("errclr", 0, 0, 0, 0, ts);
    check("errclr_err", err, 0);
    clr();
    run_prog("nops", 0, 0, 0, 10, ts);
    check("nops_pc", pc, N - 1);
    repeat (40) begin
      gen();
      run_prog("rand", 25, 0, 0, 0, ts);
    end
    clr();
    mem[0] = mk(8, 3, 0, 2); mem[1] = mk(5, 1, 2, 3); mem[2] = mk(4, 4, 5, 6); mem[3] = mk(9, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_lvl", loop_level, 1);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_iv", issue_valid, 0);
    check("mid_rst_lvl", loop_level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pc", pc, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_idle", {busy, done, issue_valid}, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/loop_decoder.md
# loop_decoder

Instruction sequencer/decoder for the SIMD array with hardware loops. Fetches instructions from the synchronous instruction memory, decodes the ALU/dot-product opcodes into registered PE, dot-unit and BRAM-write controls, and executes zero-overhead nested `LOOP` blocks through a parametrised loop stack. It sits between the instruction memory and the PE array/BRAM write path, and is started and observed by the host controller.

## Interface
- `INS_ADDR_WIDTH`, 10, instruction memory address width (program length 2^INS_ADDR_WIDTH).
- `ADDR_WIDTH`, 10, data BRAM address width; also the width of the operand fields.
- `OPCODE_WIDTH`, 4, opcode field width (minimum 4).
- `LOOP_DEPTH`, 2, loop stack entries (nesting depth, minimum 1).
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: start-program pulse; honoured in IDLE or DONE only.
- `stall` in 1: downstream back-pressure; freezes EXEC.
- `instruction` in OPCODE_WIDTH+3*ADDR_WIDTH: instruction word. Fields, LSB first: opcode, r, b, a.
- `pc` out INS_ADDR_WIDTH: instruction memory read address.
- `issue_valid` out 1: controls below are valid this cycle.
- `pe_op` out 2: PE operation. 00 pass, 01 add, 10 sub, 11 mul.
- `dot_ctrl` out 2: dot-product control. 00 off, 01 shift, 10 accumulate, 11 clear.
- `r_select` out 1: write-back source. 0 PE, 1 dot unit.
- `write_en` out 1: BRAM write enable.
- `a_addr`, `b_addr`, `r_addr` out ADDR_WIDTH each: operand and result addresses.
- `busy` out 1: program running.
- `done` out 1: program finished; held until the next `start`.
- `err` out 1: sticky error flag; cleared by `start`.
- `loop_level` out $clog2(LOOP_DEPTH+1): current stack occupancy.

## Operation
- **Opcodes:**
  - 0 NOP: no issue.
  - 1 ADD, 2 SUB, 3 MUL: pe_op 01/10/11, write_en=1, r_select=0, dot_ctrl=00.
  - 4 DOT_SHIFT, 5 DOT_ACC, 6 DOT_CLR: pe_op=11, write_en=1, r_select=1, dot_ctrl 01/10/11.
  - 7 PASS_B: pe_op=00, write_en=1, r_select=0.
  - 8 LOOP: count = a field; end = low INS_ADDR_WIDTH bits of r field; body = pc+1..end.
  - 9 HALT.
  - 10-15: illegal. Set err and treat as NOP.
- **FSM states:** IDLE, FETCH, EXEC, DONE.
  - IDLE: on start, pc←0 and go to FETCH.
  - FETCH: one cycle; memory read of pc; then go to EXEC.
  - EXEC: instruction sampled. If stall=1, stay in EXEC with no side effects. Otherwise decode, update pc, then go to FETCH, or to DONE on HALT or after executing address 2^INS_ADDR_WIDTH−1.
  - DONE: on start, pc←0, clear err, go to FETCH.
- **Issue:** NOP, LOOP, HALT and illegal opcodes never produce issue_valid.
- **LOOP, count≥1:** push {start=pc+1, end, remaining=count}, pc←pc+1.
- **LOOP, count=0:** pc←end+1, no push.
- **LOOP, end≤pc:** set err, treat as NOP.
- **LOOP, stack full:** set err, no push; body executes once.
- **Loop-back check:** after any non-HALT instruction at pc==top.end:
  - remaining>1: remaining−1, pc←top.start.
  - remaining=1: pop, pc←pc+1.
  - Only the top entry is evaluated. Nested loops sharing an end address are unsupported.
- **Program end:** reaching address 2^INS_ADDR_WIDTH−1 without a loop-back ends the program (DONE); pc does not wrap.
- **Start while busy:** ignored.

## Timing
- **Throughput:** one instruction per 2 cycles (FETCH+EXEC), plus stall cycles.
- **Issue latency:** controls are registered. Non-stalled EXEC at cycle t gives issue_valid=1 with the fields at t+1, for exactly one cycle. Otherwise issue_valid=0, write_en=0, dot_ctrl=00 and r_select=0.
- **Instruction memory:** read latency is 1 cycle; pc is stable throughout FETCH and EXEC.
- **Stall:** stall is sampled only in EXEC. Stall during FETCH has no effect.
- **Status outputs:** busy=1 from the cycle after start until the cycle HALT/end is executed. done rises together with busy falling.
- **Reset:** all outputs 0, pc=0, stack empty, state IDLE, one edge after rstn=0. Reset mid-program aborts with no further issue.

## Test plan
- Reset, start; program ADD(a=1,b=2,r=3), SUB, MUL, HALT → three single-cycle issues at cycles 3, 5, 7 after start with pe_op 01/10/11 and r_addr=3 on the first; done=1; pc=3.
- LOOP count=3 end=2, body DOT_ACC@1, DOT_SHIFT@2, HALT@3 → six issues alternating dot_ctrl 10/01, r_select=1; loop_level 1 during the body, 0 after.
- Nested LOOP count=2 (end=5) around LOOP count=3 (end=4) → inner body issues 6 times, outer-only instruction 2 times; LOOP_DEPTH=1 variant → err=1, inner body issues once per outer pass.
- LOOP count=0 end=4 at address 0 → pc jumps 0→5, nothing issued from 1-4.
- Stall held 4 cycles in EXEC on MUL → exactly one issue, after stall drops; opcode 12 → err=1, no issue; start again clears err.
- NOP-only program → done after executing address 1023, pc stays 1023; start while busy ignored; rstn low mid-loop → IDLE, issue_valid=0, loop_level=0.
